// File: rtl/buf_capture_sequencer.sv
// Sequences ADC stream snapshots into readout-buffer streams.
// Define CAPTURE_SYSREF_ALIGN_EN to hold ARM until sysref_i is high.
module buf_capture_sequencer #(
  parameter int NCHAN      = 8,
  parameter int NBUF       = 4,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_BITS   = 14,
  parameter int HOLD_BITS  = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       capture_i,
  input  logic                       sysref_i,
  input  logic [NBUF*3-1:0]          cfg_sel,
  input  logic [LEN_BITS-1:0]        cfg_len,
  input  logic [HOLD_BITS-1:0]       cfg_holdoff,
  input  logic [NCHAN*DATA_WIDTH-1:0] adc_tdata,
  input  logic [NCHAN-1:0]           adc_tvalid,
  output logic [NBUF*DATA_WIDTH-1:0] buf_tdata,
  output logic [NBUF-1:0]            buf_tvalid,
  input  logic [NBUF-1:0]            buf_tready,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overflow_o,
  output logic [15:0]                capture_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HOLDOFF,
    CAPTURE,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  cap_q;
  logic                  cap_rise;
  logic                  start;
  logic                  arm_go;
  logic                  hold_zero;
  logic                  len_zero;
  logic                  last_beat;
  logic                  in_cap;
  logic [NBUF*3-1:0]     sel_q;
  logic [LEN_BITS-1:0]   len_q;
  logic [LEN_BITS-1:0]   beat;
  logic [HOLD_BITS-1:0]  hold_cnt;
  logic [15:0]           cap_cnt;
  logic                  ovf_q;
  logic [NBUF-1:0]       vld_q;

  assign cap_rise  = capture_i & ~cap_q;
  assign start     = (state == IDLE) & cap_rise;
  assign hold_zero = (hold_cnt == '0);
  assign len_zero  = (len_q == '0);
  assign last_beat = (beat == len_q - LEN_BITS'(1));
  assign in_cap    = (state == CAPTURE);

`ifdef CAPTURE_SYSREF_ALIGN_EN
  assign arm_go = sysref_i;
`else
  logic unused_sysref;
  assign unused_sysref = sysref_i;
  assign arm_go        = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cap_rise) state_nxt = ARM;
      ARM:     if (arm_go) state_nxt = HOLDOFF;
      HOLDOFF: begin
        if (hold_zero) begin
          state_nxt = len_zero ? DONE : CAPTURE;
        end
      end
      CAPTURE: if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      cap_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cap_q <= capture_i;
    end
  end

  // Config is latched only on an accepted start; later edits wait.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sel_q    <= '0;
      len_q    <= '0;
      hold_cnt <= '0;
    end else if (start) begin
      sel_q    <= cfg_sel;
      len_q    <= cfg_len;
      hold_cnt <= cfg_holdoff;
    end else if (state == HOLDOFF && !hold_zero) begin
      hold_cnt <= hold_cnt - HOLD_BITS'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat <= '0;
    end else if (in_cap) begin
      beat <= beat + LEN_BITS'(1);
    end else begin
      beat <= '0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cap_cnt <= '0;
    end else if (state_nxt == DONE && state != DONE) begin
      cap_cnt <= cap_cnt + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ovf_q <= 1'b0;
    end else if (start) begin
      ovf_q <= 1'b0;
    end else if (|(vld_q & ~buf_tready)) begin
      ovf_q <= 1'b1;
    end
  end

  for (genvar b = 0; b < NBUF; b++) begin : g_buf
    logic [2:0]            sel;
    logic [DATA_WIDTH-1:0] mux_d;
    logic                  mux_v;
    logic [DATA_WIDTH-1:0] d_q;

    assign sel = sel_q[3*b +: 3];

    // Out-of-range selects match no channel and stay silent.
    always_comb begin
      mux_d = '0;
      mux_v = 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
        if (int'(sel) == c) begin
          mux_d = adc_tdata[c*DATA_WIDTH +: DATA_WIDTH];
          mux_v = adc_tvalid[c];
        end
      end
    end

    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        d_q      <= '0;
        vld_q[b] <= 1'b0;
      end else begin
        vld_q[b] <= in_cap & mux_v;
        if (in_cap) d_q <= mux_d;
      end
    end

    assign buf_tdata[b*DATA_WIDTH +: DATA_WIDTH] = d_q;
  end

  assign buf_tvalid      = vld_q;
  assign busy_o          = (state != IDLE);
  assign done_o          = (state == DONE);
  assign overflow_o      = ovf_q;
  assign capture_count_o = cap_cnt;

endmodule

// File: tb/tb_buf_capture_sequencer.sv
// Scoreboard bench for buf_capture_sequencer.
// Slot-level reference model; CAPTURE_SYSREF_ALIGN_EN selects the ARM model.
module tb_buf_capture_sequencer;
  localparam int NCHAN = 6;
  localparam int NBUF  = 4;
  localparam int DW    = 32;
  localparam int LB    = 6;
  localparam int HB    = 8;
  localparam int BIG   = 1 << 30;

  logic                  aclk = 1'b0;
  logic                  areset = 1'b0;
  logic                  capture_i = 1'b0;
  logic                  sysref_i = 1'b0;
  logic [NBUF*3-1:0]     cfg_sel = '0;
  logic [LB-1:0]         cfg_len = '0;
  logic [HB-1:0]         cfg_holdoff = '0;
  logic [NCHAN*DW-1:0]   adc_tdata = '0;
  logic [NCHAN-1:0]      adc_tvalid = '0;
  logic [NBUF*DW-1:0]    buf_tdata;
  logic [NBUF-1:0]       buf_tvalid;
  logic [NBUF-1:0]       buf_tready = '1;
  logic                  busy_o;
  logic                  done_o;
  logic                  overflow_o;
  logic [15:0]           capture_count_o;

  buf_capture_sequencer #(
    .NCHAN(NCHAN), .NBUF(NBUF), .DATA_WIDTH(DW),
    .LEN_BITS(LB), .HOLD_BITS(HB)
  ) dut (
    .aclk(aclk), .areset(areset),
    .capture_i(capture_i), .sysref_i(sysref_i),
    .cfg_sel(cfg_sel), .cfg_len(cfg_len),
    .cfg_holdoff(cfg_holdoff),
    .adc_tdata(adc_tdata), .adc_tvalid(adc_tvalid),
    .buf_tdata(buf_tdata), .buf_tvalid(buf_tvalid),
    .buf_tready(buf_tready),
    .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o),
    .capture_count_o(capture_count_o)
  );

  always #5 aclk = ~aclk;

  // pcnt = index of the next rising edge (slot)
  int pcnt = 0;
  always @(posedge aclk) pcnt <= pcnt + 1;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] expq[NBUF][$];
  int            ws = BIG;
  int            we = -1;
  int            cur_t = BIG;
  int            cur_d = BIG;
  int            clr_slot = -1;
  int            cnt_done = 0;
  bit            have_cur = 0;
  int            m_sel[NBUF];
  bit            ovf_m = 0;
  logic [NBUF-1:0] prev_mask = '0;
  bit            vld_rand = 0;
  bit            rdy_rand = 0;
  int            drop_slot = -1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (slot %0d)",
               nm, act, exp, pcnt);
    end
  endtask

  // Monitor for slot pcnt-1 outputs, then drive slot pcnt inputs.
  always @(negedge aclk) begin : drv
    int p;
    int q;
    logic [NBUF-1:0] mask;
    if (areset) begin
      for (int b = 0; b < NBUF; b++) expq[b].delete();
      prev_mask = '0;
    end else begin
      p = pcnt - 1;
      for (int b = 0; b < NBUF; b++) begin
        if (buf_tvalid[b]) begin
          if (expq[b].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_unexpected buf%0d: got %0h required none",
                     b, buf_tdata[b*DW +: DW]);
          end else begin
            chk($sformatf("data_buf%0d", b),
                64'(buf_tdata[b*DW +: DW]), 64'(expq[b].pop_front()));
          end
        end
      end
      chk("busy", 64'(busy_o), 64'(p >= cur_t && p <= cur_d));
      chk("done", 64'(done_o), 64'(p == cur_d));
      chk("count", 64'(capture_count_o),
          64'(16'(cnt_done + ((p >= cur_d) ? 1 : 0))));
      chk("overflow", 64'(overflow_o), 64'(ovf_m));
    end
    q = pcnt;
    for (int c = 0; c < NCHAN; c++) begin
      adc_tdata[c*DW +: DW] = DW'(q + c * 1000);
      adc_tvalid[c] = vld_rand ? ($urandom % 4 != 0) : 1'b1;
    end
    for (int b = 0; b < NBUF; b++)
      buf_tready[b] = rdy_rand ? ($urandom % 8 != 0) : 1'b1;
    if (q == drop_slot) buf_tready[2] = 1'b0;
    if (q == clr_slot) ovf_m = 0;
    else if (!areset && |(prev_mask & ~buf_tready)) ovf_m = 1;
    mask = '0;
    if (q >= ws && q <= we) begin
      for (int b = 0; b < NBUF; b++) begin
        if (m_sel[b] < NCHAN && adc_tvalid[m_sel[b]]) begin
          expq[b].push_back(DW'(q + m_sel[b] * 1000));
          mask[b] = 1'b1;
        end
      end
    end
    prev_mask = mask;
`ifndef CAPTURE_SYSREF_ALIGN_EN
    sysref_i = 1'($urandom);
`endif
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_slot(input int s);
    while (pcnt < s) step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    step();
    while (busy_o !== 1'b0 && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: got busy %0b required 0", busy_o);
    end
    for (int b = 0; b < NBUF; b++)
      chk($sformatf("missing_buf%0d", b), 64'(expq[b].size()), 64'd0);
  endtask

  task automatic do_reset(input int cyc);
    step();
    areset = 1'b1;
    capture_i = 1'b0;
    ws = BIG; we = -1; cur_t = BIG; cur_d = BIG;
    cnt_done = 0; have_cur = 0; ovf_m = 0; drop_slot = -1;
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_count", 64'(capture_count_o), 64'd0);
    chk("rst_tvalid", 64'(buf_tvalid), 64'd0);
    chk("rst_tdata_zero", 64'(buf_tdata === '0), 64'd1);
    repeat (cyc) step();
    areset = 1'b0;
  endtask

  task automatic run_cap(input logic [NBUF*3-1:0] sel, input int len,
                         input int hold, input bit drop,
                         input bit repulse, input bit rst_mid);
    int t;
    wait_idle();
    t = pcnt;
    drop_slot = -1;
    cfg_sel = sel;
    cfg_len = LB'(len);
    cfg_holdoff = HB'(hold);
    capture_i = 1'b1;
    if (have_cur) cnt_done++;
    have_cur = 1;
    cur_t = t;
    clr_slot = t;
    for (int b = 0; b < NBUF; b++) m_sel[b] = int'(sel[3*b +: 3]);
`ifdef CAPTURE_SYSREF_ALIGN_EN
    cur_d = BIG; ws = BIG; we = -1;
    step();
    capture_i = 1'b0;
    cfg_sel = NBUF*3'($urandom);
    cfg_len = LB'($urandom);
    repeat (4) step();
    capture_i = 1'b1;
    step();
    capture_i = 1'b0;
    wait_slot(t + 50);
    sysref_i = 1'b1;
    ws = pcnt + 2 + hold;
    we = pcnt + 1 + hold + len;
    cur_d = we;
    step();
    sysref_i = 1'b0;
`else
    ws = t + 3 + hold;
    we = t + 2 + hold + len;
    cur_d = we;
    step();
    capture_i = 1'b0;
    cfg_sel = NBUF*3'($urandom);
    cfg_len = LB'($urandom);
    cfg_holdoff = HB'($urandom);
`endif
    if (drop) drop_slot = ws + 2;
    if (repulse) begin
      wait_slot(ws + 1);
      capture_i = 1'b1;
      step();
      capture_i = 1'b0;
    end
    if (rst_mid) begin
      wait_slot(ws + 2);
      do_reset(3);
    end
  endtask

  initial begin
    do_reset(3);
    run_cap({3'd0, 3'd1, 3'd2, 3'd3}, 4, 0, 0, 0, 0);
    run_cap({3'd0, 3'd1, 3'd2, 3'd3}, 2, 10, 0, 0, 0);
    run_cap({3'd4, 3'd5, 3'd0, 3'd2}, 4, 3, 1, 0, 0);
    wait_idle();
    repeat (10) step();
    run_cap({3'd7, 3'd2, 3'd1, 3'd0}, 0, 2, 0, 0, 0);
    run_cap({3'd7, 3'd5, 3'd1, 3'd4}, 5, 1, 0, 0, 0);
    run_cap({3'd1, 3'd6, 3'd3, 3'd2}, 6, 2, 0, 1, 0);
    run_cap({3'd5, 3'd4, 3'd3, 3'd2}, 63, 0, 0, 0, 0);
    vld_rand = 1;
    rdy_rand = 1;
    for (int i = 0; i < 30; i++) begin
      int l;
      l = int'($urandom_range(0, 20));
      if (i % 7 == 3) l = 63;
      run_cap(NBUF*3'($urandom), l, int'($urandom_range(0, 12)),
              0, (l > 0) && ($urandom % 3 == 0), 0);
    end
    run_cap({3'd0, 3'd1, 3'd2, 3'd3}, 8, 3, 0, 0, 1);
    repeat (5) step();
    run_cap({3'd2, 3'd2, 3'd5, 3'd0}, 3, 0, 0, 0, 0);
    wait_idle();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/buf_capture_sequencer.md
Name: buf_capture_sequencer

Overview:
- Sequences snapshot captures from the eight RFDC ADC AXI4-Streams into the four readout-buffer streams.
- On a capture request it latches a per-buffer channel map, optionally aligns to SYSREF, waits a programmable holdoff, then forwards exactly cfg_len beats per buffer before returning to idle.
- Sits on aclk between the ADC stream outputs and the buffer stream inputs.
- Configuration arrives from wishbone-side registers that are already synchronised to aclk.

Parameters:
- NCHAN, 8, number of ADC input streams.
- NBUF, 4, number of readout-buffer output streams.
- DATA_WIDTH, 128, tdata width per stream.
- LEN_BITS, 14, width of the capture-length field, in beats.
- HOLD_BITS, 16, width of the holdoff field, in aclk cycles.

Ports:
- aclk  in  1  stream clock (ADC AXI4-Stream clock).
- areset  in  1  asynchronous, active-high reset.
- capture_i  in  1  capture request pulse; rising edge detected internally.
- sysref_i  in  1  SYSREF already registered into aclk.
- cfg_sel  in  NBUF*3  channel select per buffer; buffer b uses bits [3b+2:3b].
- cfg_len  in  LEN_BITS  beats to capture per buffer.
- cfg_holdoff  in  HOLD_BITS  cycles between start and first captured beat.
- adc_tdata  in  NCHAN*DATA_WIDTH  ADC stream data, channel c in slice c.
- adc_tvalid  in  NCHAN  ADC stream valid.
- buf_tdata  out  NBUF*DATA_WIDTH  buffer stream data.
- buf_tvalid  out  NBUF  buffer stream valid.
- buf_tready  in  NBUF  buffer stream ready.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when a capture completes.
- overflow_o  out  1  sticky: a buffer dropped a beat during the last capture.
- capture_count_o  out  16  completed captures; wraps modulo 2^16.

Behaviour:
- Reset (async assert, release sampled on aclk) sets: all outputs 0, state IDLE, counters 0, overflow_o 0, buf_tdata 0.
- States: IDLE, ARM, HOLDOFF, CAPTURE, DONE.
- IDLE -> ARM on capture_i rising edge.
  - In that same cycle cfg_sel, cfg_len and cfg_holdoff are latched, and overflow_o is cleared.
  - cfg changes after latching have no effect until the next capture.
- ARM -> HOLDOFF on the first cycle sysref_i is high, when alignment is compiled in (see Optional Feature). Otherwise ARM lasts exactly 1 cycle.
- HOLDOFF: counts the latched holdoff down to 0. With holdoff=0, HOLDOFF lasts 1 cycle.
- HOLDOFF -> CAPTURE when the count reaches 0. If latched len=0, go to DONE instead (no beats forwarded).
- CAPTURE:
  - Each aclk cycle is one beat slot; the beat counter increments every cycle.
  - The ADCs have no backpressure, so adc_tready is not provided.
  - After len slots, go to DONE.
- Output pipeline: one register stage.
  - buf_tdata[b] <= adc_tdata[sel_b]; buf_tvalid[b] <= in_capture & adc_tvalid[sel_b].
  - Latency from ADC beat to buffer beat: 1 cycle.
  - The last valid output appears in the cycle after CAPTURE exits.
- Out-of-range select (sel_b >= NCHAN): buf_tvalid[b] stays 0 and buf_tdata[b] stays 0. Counting is unaffected.
- Overflow: any cycle with buf_tvalid[b]=1 and buf_tready[b]=0 sets overflow_o. Data is not held; the beat is lost.
- DONE: done_o=1 for exactly 1 cycle, capture_count_o increments, then return to IDLE. busy_o=1 in DONE.
- capture_i edges outside IDLE are ignored; no queued retrigger.
- Beat counter width is LEN_BITS; a len of all-ones captures 2^LEN_BITS-1 beats with no wrap.
- areset mid-capture: outputs drop to 0 immediately; no done_o; capture_count_o resets to 0.

Optional Feature:
- Macro CAPTURE_SYSREF_ALIGN_EN.
- Defined: ARM waits for sysref_i high, so the capture start is SYSREF-aligned. A further capture_i edge while in ARM is ignored.
- Not defined: ARM always lasts 1 cycle and sysref_i is unused.

Test Plan:
- sel={3,2,1,0}, len=4, holdoff=0, all tready=1, ADC channel c data = counter + c*1000; pulse capture -> each buffer receives exactly 4 consecutive beats of its channel, done_o 1 cycle, capture_count_o=1, overflow_o=0.
- holdoff=10, len=2 -> first buf_tvalid occurs 10 cycles later than with holdoff=0; exactly 2 beats per buffer.
- buf_tready[2]=0 for one captured cycle -> overflow_o=1 and stays 1 until the next capture start; other buffers unaffected.
- len=0 -> no buf_tvalid, done_o pulses, count increments; sel_b=7 with NCHAN=6 -> buffer b silent while others capture normally.
- capture_i pulsed again mid-CAPTURE, then areset asserted mid-CAPTURE on a later run -> second pulse ignored; after reset all outputs are 0 and capture_count_o=0.
- With CAPTURE_SYSREF_ALIGN_EN, sysref_i high 50 cycles after capture -> busy_o high throughout, first beat holdoff+2 cycles after sysref_i.
